// File: rtl/clk_health_monitor.sv
// rtl/clk_health_monitor.sv - MMCM reset sequencer, lock qualifier and pixel clock frequency monitor
module clk_health_monitor #(
    parameter int MMCM_RST_CYC    = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int WINDOW_CYC      = 4096,
    parameter int CNT_MIN         = 1016,
    parameter int CNT_MAX         = 1040,
    parameter int MAX_RETRY       = 3
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clk_mon,
    input  logic        locked_in,
    output logic        mmcm_rst,
    output logic        sys_rst_out,
    output logic        clk_ok,
    output logic        fault,
    output logic [15:0] meas_count,
    output logic        meas_valid,
    output logic [3:0]  retry_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RESET_MMCM = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_MEASURE    = 3'd3,
        S_RUN        = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    // One shared timer covers the reset pulse, the lock timeout and the stable count,
    // so it must be wide enough for the largest of the three.
    localparam int TMR_MAX0 = (MMCM_RST_CYC > LOCK_TIMEOUT) ? MMCM_RST_CYC : LOCK_TIMEOUT;
    localparam int TMR_MAX  = (TMR_MAX0 > LOCK_STABLE_CYC) ? TMR_MAX0 : LOCK_STABLE_CYC;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int WIN_W    = $clog2(WINDOW_CYC + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(MMCM_RST_CYC - 1);
    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYC - 1);
    localparam logic [15:0]      CNT_LO      = 16'(CNT_MIN);
    localparam logic [15:0]      CNT_HI      = 16'(CNT_MAX);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    logic             r_mon_tog;
    logic             r_tog_s1;
    logic             r_tog_s2;
    logic             r_tog_d;
    logic             r_lock_s1;
    logic             r_lock_s2;

    state_t           r_state;
    state_t           w_next;
    logic [TMR_W-1:0] r_timer;
    logic [WIN_W-1:0] r_win;
    logic [15:0]      r_edge;
    logic [15:0]      r_meas_count;
    logic             r_meas_valid;
    logic [3:0]       r_retry;
    logic             r_sys_rst;

    logic             w_edge;
    logic             w_lock;
    logic             w_in_meas;
    logic             w_win_end;
    logic [15:0]      w_edge_total;
    logic             w_in_range;
    logic             w_fail;

    // Toggle flop in the monitored domain: each clk_mon rising edge flips it.
    always_ff @(posedge clk_mon or posedge reset) begin
        if (reset) begin
            r_mon_tog <= 1'b0;
        end else begin
            r_mon_tog <= ~r_mon_tog;
        end
    end

    // Bring the toggle and the MMCM lock into clk_in through 2-FF synchronizers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_tog_s1  <= 1'b0;
            r_tog_s2  <= 1'b0;
            r_tog_d   <= 1'b0;
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
        end else begin
            r_tog_s1  <= r_mon_tog;
            r_tog_s2  <= r_tog_s1;
            r_tog_d   <= r_tog_s2;
            r_lock_s1 <= locked_in;
            r_lock_s2 <= r_lock_s1;
        end
    end

    assign w_edge    = r_tog_s2 ^ r_tog_d;
    assign w_lock    = r_lock_s2;
    assign w_in_meas = (r_state == S_MEASURE) || (r_state == S_RUN);
    assign w_win_end = w_in_meas && (r_win == WIN_LAST);

    // Edge count including this cycle's edge, held at all-ones once it saturates.
    assign w_edge_total = (r_edge == 16'hFFFF) ? 16'hFFFF : (r_edge + {15'd0, w_edge});
    assign w_in_range   = (w_edge_total >= CNT_LO) && (w_edge_total <= CNT_HI);

    // Next-state selection and state-decoded outputs; lock loss outranks a failed window.
    always_comb begin
        w_next   = r_state;
        w_fail   = 1'b0;
        mmcm_rst = 1'b0;
        clk_ok   = 1'b0;
        fault    = 1'b0;
        case (r_state)
            S_RESET_MMCM: begin
                mmcm_rst = 1'b1;
                if (r_timer == RST_LAST) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock) begin
                    w_next = S_STABLE;
                end else if (r_timer == TO_LAST) begin
                    w_fail = 1'b1;
                end
            end
            S_STABLE: begin
                if (!w_lock) begin
                    w_next = S_WAIT_LOCK;
                end else if (r_timer == STABLE_LAST) begin
                    w_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!w_lock) begin
                    w_next = S_WAIT_LOCK;
                end else if (w_win_end) begin
                    if (w_in_range) begin
                        w_next = S_RUN;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            S_RUN: begin
                clk_ok = 1'b1;
                if (!w_lock) begin
                    w_next = S_WAIT_LOCK;
                end else if (w_win_end && !w_in_range) begin
                    w_fail = 1'b1;
                end
            end
            S_FAULT: begin
                mmcm_rst = 1'b1;
                fault    = 1'b1;
            end
            default: begin
                mmcm_rst = 1'b1;
                w_next   = S_RESET_MMCM;
            end
        endcase
        if (w_fail) begin
            w_next = (r_retry < RETRY_MAX) ? S_RESET_MMCM : S_FAULT;
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= S_RESET_MMCM;
        end else begin
            r_state <= w_next;
        end
    end

    // Per-state timer: restarts on every state change, saturates otherwise.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= '0;
        end else if (r_timer != {TMR_W{1'b1}}) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Failed attempts; only reset clears it.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_retry <= 4'd0;
        end else if (w_fail && (r_retry < RETRY_MAX)) begin
            r_retry <= r_retry + 4'd1;
        end
    end

    // Measurement windows: cleared on MEASURE entry, back-to-back while measuring.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_win        <= '0;
            r_edge       <= 16'd0;
            r_meas_count <= 16'd0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if ((w_next == S_MEASURE) && (r_state != S_MEASURE)) begin
                r_win  <= '0;
                r_edge <= 16'd0;
            end else if (w_in_meas) begin
                if (w_win_end) begin
                    r_win        <= '0;
                    r_edge       <= {15'd0, w_edge};
                    r_meas_count <= w_edge_total;
                    r_meas_valid <= 1'b1;
                end else begin
                    r_win  <= r_win + 1'b1;
                    r_edge <= w_edge_total;
                end
            end
        end
    end

    // Downstream reset drops on the first RUN cycle and rises the cycle after RUN is left.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sys_rst <= 1'b1;
        end else begin
            r_sys_rst <= (w_next != S_RUN);
        end
    end

    assign sys_rst_out = r_sys_rst;
    assign meas_count  = r_meas_count;
    assign meas_valid  = r_meas_valid;
    assign retry_cnt   = r_retry;
    assign state       = r_state;

endmodule

// File: tb/tb_clk_health_monitor.sv
// tb/tb_clk_health_monitor.sv - directed self-checking bench for clk_health_monitor
module tb_clk_health_monitor;

    localparam int TO_CYC = 1000;

    logic        clk_in;
    logic        reset;
    logic        clk_mon;
    logic        locked_in;
    logic        mmcm_rst;
    logic        sys_rst_out;
    logic        clk_ok;
    logic        fault;
    logic [15:0] meas_count;
    logic        meas_valid;
    logic [3:0]  retry_cnt;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int mon_half = 20;

    clk_health_monitor #(
        .LOCK_TIMEOUT (TO_CYC)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .clk_mon     (clk_mon),
        .locked_in   (locked_in),
        .mmcm_rst    (mmcm_rst),
        .sys_rst_out (sys_rst_out),
        .clk_ok      (clk_ok),
        .fault       (fault),
        .meas_count  (meas_count),
        .meas_valid  (meas_valid),
        .retry_cnt   (retry_cnt),
        .state       (state)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        clk_mon = 1'b0;
        #3;
        forever #(mon_half) clk_mon = ~clk_mon;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 1);
        chk({tag, "_sys_rst"}, 32'(sys_rst_out), 1);
        chk({tag, "_clk_ok"}, 32'(clk_ok), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_meas_count"}, 32'(meas_count), 0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 0);
        chk({tag, "_retry"}, 32'(retry_cnt), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        reset     = 1'b1;
        locked_in = 1'b0;
        tick(5);
        chk_reset_vals("por");

        // Nominal start: 40 ns pixel clock, lock arrives 200 cycles after release.
        @(negedge clk_in);
        reset = 1'b0;
        tick(15);
        chk("nom_rst_hold_state", 32'(state), 0);
        chk("nom_rst_hold_mmcm", 32'(mmcm_rst), 1);
        tick(1);
        chk("nom_wait_state", 32'(state), 1);
        chk("nom_wait_mmcm", 32'(mmcm_rst), 0);
        tick(184);
        locked_in = 1'b1;
        tick(2);
        chk("nom_sync_latency", 32'(state), 1);
        tick(1);
        chk("nom_stable_enter", 32'(state), 2);
        tick(1023);
        chk("nom_stable_hold", 32'(state), 2);
        tick(1);
        chk("nom_measure_enter", 32'(state), 3);
        chk("nom_measure_sysrst", 32'(sys_rst_out), 1);
        tick(4095);
        chk("nom_measure_hold", 32'(state), 3);
        chk("nom_no_valid_early", 32'(meas_valid), 0);
        tick(1);
        chk("nom_run_state", 32'(state), 4);
        chk("nom_valid_pulse", 32'(meas_valid), 1);
        chk("nom_count_range", 32'((meas_count >= 16'd1023) && (meas_count <= 16'd1025)), 1);
        chk("nom_run_sysrst", 32'(sys_rst_out), 0);
        chk("nom_run_clk_ok", 32'(clk_ok), 1);
        chk("nom_run_retry", 32'(retry_cnt), 0);
        tick(1);
        chk("nom_valid_one_cycle", 32'(meas_valid), 0);
        tick(4095);
        chk("nom_run_window2_valid", 32'(meas_valid), 1);
        chk("nom_run_window2_state", 32'(state), 4);
        chk("nom_run_window2_range", 32'((meas_count >= 16'd1023) && (meas_count <= 16'd1025)), 1);

        // Lock loss in RUN.
        locked_in = 1'b0;
        tick(2);
        chk("ll_still_run", 32'(state), 4);
        tick(1);
        chk("ll_state", 32'(state), 1);
        chk("ll_sysrst", 32'(sys_rst_out), 1);
        chk("ll_clk_ok", 32'(clk_ok), 0);
        chk("ll_retry", 32'(retry_cnt), 0);
        locked_in = 1'b1;
        tick(3 + 1024 + 4095);
        chk("ll_remeasure", 32'(state), 3);
        tick(1);
        chk("ll_back_run", 32'(state), 4);
        chk("ll_back_sysrst", 32'(sys_rst_out), 0);
        chk("ll_back_retry", 32'(retry_cnt), 0);

        // Lock glitch of 3 cycles at stable count 500.
        locked_in = 1'b0;
        tick(3);
        chk("gl_wait", 32'(state), 1);
        locked_in = 1'b1;
        tick(3);
        chk("gl_stable", 32'(state), 2);
        tick(500);
        locked_in = 1'b0;
        tick(3);
        chk("gl_drop_wait", 32'(state), 1);
        locked_in = 1'b1;
        tick(2);
        chk("gl_wait_sync", 32'(state), 1);
        tick(1);
        chk("gl_restable", 32'(state), 2);
        tick(1023);
        chk("gl_restart_hold", 32'(state), 2);
        tick(1);
        chk("gl_measure", 32'(state), 3);
        tick(4096);
        chk("gl_run", 32'(state), 4);

        // Asynchronous reset between clk_in edges while in RUN.
        tick(10);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");

        // Restart with lock held low: lock timeout path.
        locked_in = 1'b0;
        tick(3);
        @(negedge clk_in);
        reset = 1'b0;
        tick(16);
        chk("to_wait", 32'(state), 1);
        tick(TO_CYC - 1);
        chk("to_hold_state", 32'(state), 1);
        chk("to_hold_retry", 32'(retry_cnt), 0);
        tick(1);
        chk("to_state", 32'(state), 0);
        chk("to_retry", 32'(retry_cnt), 1);
        chk("to_mmcm", 32'(mmcm_rst), 1);

        // Wrong frequency: 30 ns pixel clock, every window out of range.
        reset     = 1'b1;
        mon_half  = 15;
        locked_in = 1'b1;
        tick(5);
        @(negedge clk_in);
        reset = 1'b0;
        tick(5136);
        chk("wf_measure", 32'(state), 3);
        chk("wf_sysrst", 32'(sys_rst_out), 1);
        tick(1);
        chk("wf_fail1_state", 32'(state), 0);
        chk("wf_fail1_retry", 32'(retry_cnt), 1);
        chk("wf_fail1_valid", 32'(meas_valid), 1);
        chk("wf_count_range", 32'((meas_count >= 16'd1360) && (meas_count <= 16'd1370)), 1);
        for (int r = 2; r <= 3; r++) begin
            tick(15);
            chk("wf_pulse_high", 32'(mmcm_rst), 1);
            tick(1);
            chk("wf_pulse_low", 32'(mmcm_rst), 0);
            tick(5121);
            chk("wf_retry_state", 32'(state), 0);
            chk("wf_retry_cnt", 32'(retry_cnt), 32'(r));
        end
        tick(5137);
        chk("wf_fault_state", 32'(state), 5);
        chk("wf_fault_flag", 32'(fault), 1);
        chk("wf_fault_mmcm", 32'(mmcm_rst), 1);
        chk("wf_fault_sysrst", 32'(sys_rst_out), 1);
        chk("wf_fault_clk_ok", 32'(clk_ok), 0);
        chk("wf_fault_retry", 32'(retry_cnt), 3);
        tick(50);
        chk("wf_fault_sticky", 32'(state), 5);
        chk("wf_fault_sticky_flag", 32'(fault), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
